// File: rtl/bcd_updown_counter_n.sv
// NDIG-digit BCD up/down counter with an inclusive, live upper limit. It either wraps or
// saturates at the terminals and drives cascadable carry/borrow strobes.
module bcd_updown_counter_n #(
  parameter int unsigned NDIG     = 2,
  parameter bit          SATURATE = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              load,
  input  logic [4*NDIG-1:0] load_value,
  input  logic              en,
  input  logic              dir,
  input  logic [4*NDIG-1:0] limit,
  output logic [4*NDIG-1:0] value,
  output logic              carry,
  output logic              borrow,
  output logic              at_term
);

  localparam int unsigned W = 4 * NDIG;

  logic [W-1:0] value_q, value_d;
  logic [W-1:0] lim_s, ld_clamp, ld_fit;
  logic [W-1:0] inc_val, dec_val;
  logic         val_zero, val_ge_lim, val_gt_lim;
  logic         up_ev, dn_ev, quiet;

  // Force out-of-range digits to 9 on both the limit and the load value.
  always_comb begin
    lim_s    = limit;
    ld_clamp = load_value;
    for (int unsigned i = 0; i < NDIG; i++) begin
      if (limit[4*i +: 4] > 4'd9) begin
        lim_s[4*i +: 4] = 4'd9;
      end
      if (load_value[4*i +: 4] > 4'd9) begin
        ld_clamp[4*i +: 4] = 4'd9;
      end
    end
  end

  // All operands hold valid BCD digits here, so a plain binary compare orders them numerically.
  assign ld_fit     = (ld_clamp > lim_s) ? lim_s : ld_clamp;
  assign val_zero   = (value_q == {W{1'b0}});
  assign val_ge_lim = (value_q >= lim_s);
  assign val_gt_lim = (value_q > lim_s);

  // Increment with decimal ripple.
  always_comb begin
    logic cy;
    inc_val = value_q;
    cy      = 1'b1;
    for (int unsigned i = 0; i < NDIG; i++) begin
      if (cy) begin
        if (value_q[4*i +: 4] == 4'd9) begin
          inc_val[4*i +: 4] = 4'd0;
        end else begin
          inc_val[4*i +: 4] = value_q[4*i +: 4] + 4'd1;
          cy                = 1'b0;
        end
      end
    end
  end

  // Decrement with decimal borrow ripple.
  always_comb begin
    logic bw;
    dec_val = value_q;
    bw      = 1'b1;
    for (int unsigned i = 0; i < NDIG; i++) begin
      if (bw) begin
        if (value_q[4*i +: 4] == 4'd0) begin
          dec_val[4*i +: 4] = 4'd9;
        end else begin
          dec_val[4*i +: 4] = value_q[4*i +: 4] - 4'd1;
          bw                = 1'b0;
        end
      end
    end
  end

  always_comb begin
    value_d = value_q;
    if (clear) begin
      value_d = {W{1'b0}};
    end else if (load) begin
      value_d = ld_fit;
    end else if (en) begin
      if (dir) begin
        if (val_ge_lim) begin
          value_d = SATURATE ? lim_s : {W{1'b0}};
        end else begin
          value_d = inc_val;
        end
      end else begin
        if (val_zero) begin
          value_d = SATURATE ? {W{1'b0}} : lim_s;
        end else if (val_gt_lim) begin
          value_d = lim_s;
        end else begin
          value_d = dec_val;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= {W{1'b0}};
    end else begin
      value_q <= value_d;
    end
  end

  // Strobes are masked during reset so a limit of 0 cannot fire carry while held in reset.
  assign quiet   = ~rst_n | clear | load;
  assign up_ev   = en & dir & val_ge_lim;
  assign dn_ev   = en & ~dir & val_zero;
  assign carry   = up_ev & ~quiet;
  assign borrow  = dn_ev & ~quiet;
  assign at_term = dir ? val_ge_lim : val_zero;
  assign value   = value_q;

endmodule

// File: tb/tb_bcd_updown_counter_n.sv
// Scoreboard bench for bcd_updown_counter_n: one wrapping and one saturating instance share
// stimulus and are checked against a decimal-integer reference model.
module tb_bcd_updown_counter_n;

  localparam int NDIG = 2;
  localparam int W    = 4 * NDIG;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         clear = 1'b0;
  logic         load = 1'b0;
  logic         en = 1'b0;
  logic         dir = 1'b1;
  logic [W-1:0] load_value = '0;
  logic [W-1:0] limit = 8'h59;
  logic [W-1:0] value_w, value_s;
  logic         carry_w, borrow_w, at_term_w;
  logic         carry_s, borrow_s, at_term_s;

  typedef struct {
    int v_w;
    int v_s;
    bit c_w, b_w, t_w;
    bit c_s, b_s, t_s;
  } exp_t;

  exp_t sb_q[$];
  int   m_w, m_s;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  bcd_updown_counter_n #(.NDIG(NDIG), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .clear(clear), .load(load), .load_value(load_value),
    .en(en), .dir(dir), .limit(limit), .value(value_w), .carry(carry_w),
    .borrow(borrow_w), .at_term(at_term_w)
  );

  bcd_updown_counter_n #(.NDIG(NDIG), .SATURATE(1'b1)) u_sat (
    .clk(clk), .rst_n(rst_n), .clear(clear), .load(load), .load_value(load_value),
    .en(en), .dir(dir), .limit(limit), .value(value_s), .carry(carry_s),
    .borrow(borrow_s), .at_term(at_term_s)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int bcd2int(input logic [W-1:0] b);
    int r, d;
    r = 0;
    for (int i = NDIG - 1; i >= 0; i--) begin
      d = int'(b[4*i +: 4]);
      if (d > 9) d = 9;
      r = r * 10 + d;
    end
    return r;
  endfunction

  function automatic logic [W-1:0] int2bcd(input int v);
    logic [W-1:0] r;
    int t;
    r = '0;
    t = v;
    for (int i = 0; i < NDIG; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Reference: one cycle of the counter on decimal integers, using the currently driven inputs.
  function automatic void model_step(input bit sat, input int v, output int nv,
                                     output bit c, output bit b, output bit t);
    int lim, ld;
    lim = bcd2int(limit);
    c   = 1'b0;
    b   = 1'b0;
    nv  = v;
    t   = dir ? (v >= lim) : (v == 0);
    if (clear) begin
      nv = 0;
    end else if (load) begin
      ld = bcd2int(load_value);
      nv = (ld > lim) ? lim : ld;
    end else if (en) begin
      if (dir) begin
        if (v >= lim) begin
          c  = 1'b1;
          nv = sat ? lim : 0;
        end else begin
          nv = v + 1;
        end
      end else begin
        if (v == 0) begin
          b  = 1'b1;
          nv = sat ? 0 : lim;
        end else if (v > lim) begin
          nv = lim;
        end else begin
          nv = v - 1;
        end
      end
    end
  endfunction

  task automatic cyc(input logic cl, input logic ld, input logic [W-1:0] lv,
                     input logic e, input logic d, input logic [W-1:0] lm);
    exp_t x, y;
    int   nw, ns;
    bit   cw, bw, tw, cs, bs, ts;
    logic oc_w, ob_w, ot_w, oc_s, ob_s, ot_s;
    @(negedge clk);
    clear = cl;
    load = ld;
    load_value = lv;
    en = e;
    dir = d;
    limit = lm;
    model_step(1'b0, m_w, nw, cw, bw, tw);
    model_step(1'b1, m_s, ns, cs, bs, ts);
    x.v_w = nw; x.c_w = cw; x.b_w = bw; x.t_w = tw;
    x.v_s = ns; x.c_s = cs; x.b_s = bs; x.t_s = ts;
    m_w = nw;
    m_s = ns;
    sb_q.push_back(x);
    #1;
    oc_w = carry_w; ob_w = borrow_w; ot_w = at_term_w;
    oc_s = carry_s; ob_s = borrow_s; ot_s = at_term_s;
    @(posedge clk);
    #1;
    y = sb_q.pop_front();
    check_eq("carry_wrap", 32'(oc_w), 32'(y.c_w));
    check_eq("borrow_wrap", 32'(ob_w), 32'(y.b_w));
    check_eq("at_term_wrap", 32'(ot_w), 32'(y.t_w));
    check_eq("value_wrap", 32'(value_w), 32'(int2bcd(y.v_w)));
    check_eq("carry_sat", 32'(oc_s), 32'(y.c_s));
    check_eq("borrow_sat", 32'(ob_s), 32'(y.b_s));
    check_eq("at_term_sat", 32'(ot_s), 32'(y.t_s));
    check_eq("value_sat", 32'(value_s), 32'(int2bcd(y.v_s)));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] rl, rlv;
    logic rc, rld, re, rd;
    m_w = 0;
    m_s = 0;

    #1;
    check_eq("rst_value_wrap", 32'(value_w), 32'h0);
    check_eq("rst_value_sat", 32'(value_s), 32'h0);
    check_eq("rst_carry", 32'(carry_w), 32'h0);
    check_eq("rst_borrow", 32'(borrow_w), 32'h0);
    check_eq("rst_at_term", 32'(at_term_w), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Up through limit 59, then down across zero.
    repeat (60) cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h59);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h59);
    repeat (3) cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h59);

    // Digit boundaries.
    cyc(1'b0, 1'b1, 8'h09, 1'b0, 1'b1, 8'h99);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h99);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h99);
    cyc(1'b0, 1'b1, 8'h90, 1'b0, 1'b0, 8'h99);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h99);

    // Priority and load clamping.
    cyc(1'b1, 1'b1, 8'h3A, 1'b1, 1'b1, 8'h99);
    cyc(1'b0, 1'b1, 8'h3A, 1'b0, 1'b1, 8'h99);
    cyc(1'b0, 1'b1, 8'h75, 1'b1, 1'b0, 8'h50);
    cyc(1'b0, 1'b1, 8'hFF, 1'b0, 1'b1, 8'h1F);

    // Terminal behaviour around limit 12.
    cyc(1'b0, 1'b1, 8'h11, 1'b0, 1'b1, 8'h12);
    repeat (3) cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h12);
    cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h12);
    repeat (2) cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h12);

    // Limit zero pins value at 0.
    repeat (2) cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h00);
    repeat (2) cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00);

    // Random mix, including live limit changes and invalid digits.
    rl = 8'h73;
    for (int k = 0; k < 300; k++) begin
      rc  = ($urandom % 16) == 0;
      rld = ($urandom % 8) == 0;
      rlv = W'($urandom);
      re  = ($urandom % 4) != 0;
      rd  = ($urandom % 2) == 1;
      if (($urandom % 16) == 0) rl = W'($urandom);
      cyc(rc, rld, rlv, re, rd, rl);
    end

    // Asynchronous reset mid-count.
    cyc(1'b0, 1'b1, 8'h47, 1'b0, 1'b1, 8'h99);
    @(negedge clk);
    clear = 1'b0;
    load = 1'b0;
    en = 1'b1;
    dir = 1'b1;
    limit = 8'h00;
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_value_wrap", 32'(value_w), 32'h0);
    check_eq("async_rst_value_sat", 32'(value_s), 32'h0);
    check_eq("async_rst_carry_wrap", 32'(carry_w), 32'h0);
    check_eq("async_rst_carry_sat", 32'(carry_s), 32'h0);
    check_eq("async_rst_borrow", 32'(borrow_w), 32'h0);
    check_eq("async_rst_at_term", 32'(at_term_w), 32'h1);
    @(posedge clk);
    #1;
    check_eq("rst_hold_value", 32'(value_w), 32'h0);
    #1;
    rst_n = 1'b1;
    m_w = 0;
    m_s = 0;
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h99);
    cyc(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h99);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
